// File: rtl/hilo_muldiv_unit_if.sv
// Issue/result bundle between the pipeline (master) and the HI/LO multiply/divide unit (slave).
// Carries the decoder flags, operands, MTHI/MTLO write port and the committed HI/LO view.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             mult;
  logic             div;
  logic             isUnsigned;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wData;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, mult, div, isUnsigned, opA, opB, mthi, mtlo, wData,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, mult, div, isUnsigned, opA, opB, mthi, mtlo, wData,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO registers.
// Works on operand magnitudes; a FIX cycle applies signs and special cases before committing HI/LO.
module hilo_muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1   // 1, 2 or 4 multiplier bits per cycle
) (
  input  logic                clk,
  input  logic                rstN,
  hilo_muldiv_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam int                 CNT_W     = $clog2(WIDTH);
  localparam int                 MUL_STEPS = WIDTH / RADIX_BITS;
  localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
  localparam logic [CNT_W-1:0]   MUL_LAST  = CNT_W'(MUL_STEPS - 1);
  localparam logic [CNT_W-1:0]   DIV_LAST  = CNT_W'(WIDTH - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;        // product, or {remainder, quotient} shift register
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     dividend_raw;
  logic                 is_div;
  logic                 neg_q;      // product / quotient sign
  logic                 neg_r;      // remainder follows the dividend
  logic                 div_zero;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 sgn;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   mul_next;
  logic                 div_fits;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     fix_hi;
  logic [WIDTH-1:0]     fix_lo;

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sgn   = !bus.isUnsigned;
    mag_a = (sgn && bus.opA[WIDTH-1]) ? -bus.opA : bus.opA;
    mag_b = (sgn && bus.opB[WIDTH-1]) ? -bus.opB : bus.opB;

    mul_next = acc;
    for (int k = 0; k < RADIX_BITS; k++) begin
      if (mplier[k]) mul_next = mul_next + (mcand << k);
    end

    // Shifted partial remainder can reach WIDTH+1 bits, so compare at that width.
    div_fits = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, divisor};
    div_diff = WIDTH'(acc[2*WIDTH-1:WIDTH-1] - {1'b0, divisor});
    div_next = div_fits ? {div_diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};

    prod_fix = neg_q ? -acc : acc;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = dividend_raw;
        fix_lo = '1;
      end else begin
        fix_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      divisor      <= '0;
      dividend_raw <= '0;
      is_div       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            // A start strobe always suppresses a same-cycle MTHI/MTLO.
            if (bus.mult || bus.div) begin
              busy_q <= 1'b1;
              cnt    <= '0;
              neg_q  <= sgn && (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
              neg_r  <= sgn && bus.opA[WIDTH-1];
              if (bus.mult) begin
                state  <= MUL;
                is_div <= 1'b0;
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, mag_a};
                mplier <= mag_b;
              end else begin
                state        <= DIV;
                is_div       <= 1'b1;
                acc          <= {{WIDTH{1'b0}}, mag_a};
                divisor      <= mag_b;
                dividend_raw <= bus.opA;
                div_zero     <= (bus.opB == '0);
              end
            end
          end else begin
            if (bus.mthi) hi_q <= bus.wData;
            if (bus.mtlo) lo_q <= bus.wData;
          end
        end
        MUL: begin
          acc    <= mul_next;
          mcand  <= mcand << RADIX_BITS;
          mplier <= mplier >> RADIX_BITS;
          cnt    <= cnt + CNT_ONE;
          if (cnt == MUL_LAST) state <= FIX;
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + CNT_ONE;
          if (cnt == DIV_LAST) state <= FIX;
        end
        FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench: RADIX_BITS=1 and RADIX_BITS=4 units driven in lockstep and compared
// against an arithmetic model of MULT/DIV results, latencies and HI/LO update rules.
module tb_hilo_muldiv_unit;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(32)) bus1 ();
  hilo_muldiv_unit_if #(.WIDTH(32)) bus4 ();

  hilo_muldiv_unit #(.WIDTH(32), .RADIX_BITS(1)) u_r1 (.clk(clk), .rstN(rstN), .bus(bus1));
  hilo_muldiv_unit #(.WIDTH(32), .RADIX_BITS(4)) u_r4 (.clk(clk), .rstN(rstN), .bus(bus4));

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_hi   = '0;
  logic [31:0] exp_lo   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, m, d, u, input logic [31:0] a, b,
                       input logic mh, ml, input logic [31:0] wd);
    bus1.start = st; bus1.mult = m; bus1.div = d; bus1.isUnsigned = u;
    bus1.opA = a; bus1.opB = b; bus1.mthi = mh; bus1.mtlo = ml; bus1.wData = wd;
    bus4.start = st; bus4.mult = m; bus4.div = d; bus4.isUnsigned = u;
    bus4.opA = a; bus4.opB = b; bus4.mthi = mh; bus4.mtlo = ml; bus4.wData = wd;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic is_mul, input logic uns,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    int          ia, ib;
    logic [63:0] p;
    if (is_mul) begin
      if (uns) p = {32'b0, a} * {32'b0, b};
      else begin
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
      end
      return p;
    end
    if (b == 32'b0) return {a, 32'hFFFF_FFFF};
    if (uns) return {a % b, a / b};
    ia = a;
    ib = b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    return {32'(ia % ib), 32'(ia / ib)};
  endfunction

  task automatic watch(input string tag, input int n, input int lat,
                       input logic d, input logic b, input logic [31:0] h, input logic [31:0] l,
                       input logic [63:0] r, inout int cnt, inout int got);
    if (n == lat - 1) begin
      check({tag, " hi held"}, h, exp_hi);
      check({tag, " busy mid"}, {31'b0, b}, 32'd1);
    end
    if (d === 1'b1) begin
      cnt++;
      if (cnt == 1) begin
        got = n;
        check({tag, " hi"}, h, r[63:32]);
        check({tag, " lo"}, l, r[31:0]);
        check({tag, " busy at done"}, {31'b0, b}, 32'd0);
      end
    end
  endtask

  // Issues one operation at edge E0 and follows it for 40 edges. With noise set, div rides
  // along with mult, a move accompanies start, and start/mthi/mtlo are poked while busy.
  task automatic run_op(input string tag, input logic is_mul, input logic uns,
                        input logic [31:0] a, input logic [31:0] b, input bit noise);
    logic [63:0] r;
    int lat1, lat4, got1, got4, cnt1, cnt4;
    r    = model(is_mul, uns, a, b);
    lat1 = 33;
    lat4 = is_mul ? 9 : 33;
    got1 = -1; got4 = -1; cnt1 = 0; cnt4 = 0;
    @(negedge clk);
    drive(1'b1, is_mul, !is_mul || noise, uns, a, b, noise, noise, $urandom);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    check({tag, " r1 busy after E0"}, {31'b0, bus1.busy}, 32'd1);
    check({tag, " r4 busy after E0"}, {31'b0, bus4.busy}, 32'd1);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      watch({tag, " r1"}, n, lat1, bus1.done, bus1.busy, bus1.hi, bus1.lo, r, cnt1, got1);
      watch({tag, " r4"}, n, lat4, bus4.done, bus4.busy, bus4.hi, bus4.lo, r, cnt4, got4);
      if (noise && n == 5) drive(1'b1, 1'b1, 1'b1, ~uns, $urandom, $urandom, 1'b1, 1'b1, $urandom);
      if (noise && n == 6) drive_idle();
    end
    check({tag, " r1 latency"}, 32'(got1), 32'(lat1));
    check({tag, " r4 latency"}, 32'(got4), 32'(lat4));
    check({tag, " r1 done count"}, 32'(cnt1), 32'd1);
    check({tag, " r4 done count"}, 32'(cnt4), 32'd1);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
  endtask

  task automatic idle_move(input string tag, input logic mh, input logic ml, input logic [31:0] wd);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom, mh, ml, wd);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    if (mh) exp_hi = wd;
    if (ml) exp_lo = wd;
    check({tag, " r1 hi"}, bus1.hi, exp_hi);
    check({tag, " r1 lo"}, bus1.lo, exp_lo);
    check({tag, " r4 hi"}, bus4.hi, exp_hi);
    check({tag, " r4 lo"}, bus4.lo, exp_lo);
    check({tag, " r1 no done"}, {31'b0, bus1.done}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(0, 20));
      4:       v = -32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int dones;
    rstN = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    check("reset r1 hi", bus1.hi, 32'h0);
    check("reset r1 lo", bus1.lo, 32'h0);
    check("reset r1 busy", {31'b0, bus1.busy}, 32'd0);
    check("reset r1 done", {31'b0, bus1.done}, 32'd0);
    check("reset r4 hi", bus4.hi, 32'h0);
    check("reset r4 busy", {31'b0, bus4.busy}, 32'd0);

    run_op("multu max", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu max hi const", exp_hi, 32'hFFFF_FFFE);
    run_op("mult -3*5", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op("div -7/2", 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu 7/2", 1'b0, 1'b1, 32'd7, 32'd2, 1'b0);
    run_op("div min/-1", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu by 0", 1'b0, 1'b1, 32'h0000_1234, 32'd0, 1'b0);
    run_op("div neg by 0", 1'b0, 1'b0, 32'hFFFF_FF00, 32'd0, 1'b0);
    run_op("mult min*min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);

    idle_move("mthi", 1'b1, 1'b0, 32'h0000_00A5);
    idle_move("mtlo", 1'b0, 1'b1, 32'h0000_5A5A);
    idle_move("mthi+mtlo", 1'b1, 1'b1, 32'hDEAD_BEEF);

    run_op("div noisy", 1'b0, 1'b0, 32'd1000, 32'hFFFF_FFF9, 1'b1);
    run_op("mult noisy", 1'b1, 1'b1, 32'h0001_0003, 32'h0000_7001, 1'b1);

    // Reset asserted at edge 10 of a DIV discards it without a done pulse.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    dones = 0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus1.done === 1'b1 || bus4.done === 1'b1) dones++;
    end
    rstN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstN   = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    check("midreset r1 hi", bus1.hi, 32'h0);
    check("midreset r1 lo", bus1.lo, 32'h0);
    check("midreset r1 busy", {31'b0, bus1.busy}, 32'd0);
    check("midreset r4 busy", {31'b0, bus4.busy}, 32'd0);
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus1.done === 1'b1 || bus4.done === 1'b1) dones++;
    end
    check("midreset no done", 32'(dones), 32'd0);
    check("midreset r1 hi later", bus1.hi, 32'h0);
    run_op("multu 2*3", 1'b1, 1'b1, 32'd2, 32'd3, 1'b0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0)
        idle_move($sformatf("rnd%0d move", i), 1'($urandom), 1'($urandom), $urandom);
      run_op($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), rnd_operand(), rnd_operand(),
             ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
